// File: rtl/mbist_pattern_seq.sv
// MBIST background-pattern sequencer: steps through each pattern and each address 0..DEPTH-1.
// Defining MBIST_PATSEQ_WALK_EN adds walking-one (6) and walking-zero (7) patterns.
module mbist_pattern_seq #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data_t,
    output logic [ADDR_W-1:0] addr,
    output logic [2:0]        pat_idx,
    output logic              busy,
    output logic              done
);

`ifdef MBIST_PATSEQ_WALK_EN
    localparam int NUM_PAT = 8;
    localparam int BP_W    = $clog2(DATA_W);
    localparam logic [BP_W-1:0] LAST_BP = BP_W'(DATA_W - 1);
`else
    localparam int NUM_PAT = 6;
`endif
    localparam int H = DATA_W / 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        LAST_PAT  = 3'(NUM_PAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   xfer;
    logic   last_beat;

    // Handshake: a beat transfers on every cycle where valid && ready; while
    // valid is high and ready is low, addr, pat_idx and data_t hold steady.
    assign valid     = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign xfer      = valid && ready;
    assign last_beat = (addr == LAST_ADDR) && (pat_idx == LAST_PAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (xfer && last_beat) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
        end
    end

    // Counters are cleared outside RUN so every sweep starts at pattern 0, addr 0.
    always_ff @(posedge clk) begin
        if (rst || abort || (state != RUN)) begin
            addr    <= '0;
            pat_idx <= '0;
        end else if (xfer) begin
            if (addr == LAST_ADDR) begin
                addr    <= '0;
                pat_idx <= (pat_idx == LAST_PAT) ? 3'd0 : pat_idx + 3'd1;
            end else begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

`ifdef MBIST_PATSEQ_WALK_EN
    // Walking-bit position tracks addr mod DATA_W without a divider.
    logic [BP_W-1:0] bit_pos;

    always_ff @(posedge clk) begin
        if (rst || abort || (state != RUN)) begin
            bit_pos <= '0;
        end else if (xfer) begin
            if ((addr == LAST_ADDR) || (bit_pos == LAST_BP)) begin
                bit_pos <= '0;
            end else begin
                bit_pos <= bit_pos + BP_W'(1);
            end
        end
    end
`endif

    always_comb begin
        data_t = '0;
        if (valid) begin
            for (int i = 0; i < DATA_W; i++) begin
                case (pat_idx)
                    3'd0:    data_t[i] = ((i % 2) == 1);
                    3'd1:    data_t[i] = ((i % 2) == 0);
                    3'd2:    data_t[i] = (i >= H);
                    3'd3:    data_t[i] = (i < H);
                    3'd4:    data_t[i] = 1'b0;
                    3'd5:    data_t[i] = 1'b1;
`ifdef MBIST_PATSEQ_WALK_EN
                    3'd6:    data_t[i] = (bit_pos == BP_W'(i));
                    3'd7:    data_t[i] = (bit_pos != BP_W'(i));
`endif
                    default: data_t[i] = 1'b0;
                endcase
            end
        end
    end

endmodule
